// File: rtl/lifo_drain_ctrl.sv
// LIFO consumer: issues POP strobes, absorbs the one-cycle read latency and streams words out
// through a 2-entry skid buffer. Defining DRAIN_POPCNT_EN enables the saturating pop counter.
module lifo_drain_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int LIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(LIFO_DEPTH + 1)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  drain_en,
    output logic                  lifo_pop,
    input  logic [DATA_WIDTH-1:0] lifo_data,
    input  logic                  lifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  drain_done,
    output logic [CNT_W-1:0]      pop_count
);
    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic                  exhausted_q, exhausted_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  valid_q, busy_q, done_q;
    logic                  fire;
    logic [1:0]            occAfterFire;
    logic [2:0]            pending;

    assign fire    = valid_q & m_ready;
    // Words owed to the skid buffer after this cycle's fire; a pop may only add one more.
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, fire};

    assign lifo_pop = !Rst && (state_q == DRAIN) && drain_en && !lifo_empty && (pending < 3'd2);

    assign m_valid    = valid_q;
    assign m_data     = head_q;
    assign busy       = busy_q;
    assign drain_done = done_q;

    always_comb begin
        occAfterFire = occ_q - {1'b0, fire};
        occ_d        = occAfterFire;
        head_d       = head_q;
        tail_d       = tail_q;
        if (fire && occ_q == 2'd2) begin
            head_d = tail_q;
        end
        // The captured word goes straight to the head when nothing is left ahead of it.
        if (inflight_q) begin
            occ_d = occAfterFire + 2'd1;
            if (occAfterFire == 2'd0) begin
                head_d = lifo_data;
            end else begin
                tail_d = lifo_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        exhausted_d = exhausted_q;
        case (state_q)
            IDLE: begin
                if (drain_en) begin
                    state_d     = DRAIN;
                    exhausted_d = 1'b0;
                end
            end
            DRAIN: begin
                if (lifo_empty) begin
                    state_d     = FLUSH;
                    exhausted_d = 1'b1;
                end else if (!drain_en) begin
                    state_d     = FLUSH;
                    exhausted_d = 1'b0;
                end
            end
            FLUSH: begin
                if (!inflight_q && occ_q == 2'd0) begin
                    state_d = exhausted_q ? DONE : IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            occ_q       <= 2'd0;
            inflight_q  <= 1'b0;
            exhausted_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            inflight_q  <= lifo_pop;
            exhausted_q <= exhausted_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            valid_q     <= (occ_d != 2'd0);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

`ifdef DRAIN_POPCNT_EN
    logic [CNT_W-1:0] popCount_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            popCount_q <= '0;
        end else if (state_q == IDLE && drain_en) begin
            popCount_q <= '0;
        end else if (lifo_pop && popCount_q != CNT_W'(LIFO_DEPTH)) begin
            popCount_q <= popCount_q + CNT_W'(1);
        end
    end

    assign pop_count = popCount_q;
`else
    assign pop_count = '0;
`endif

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// Bench for lifo_drain_ctrl: a queue-based LIFO model feeds the DUT, and every output word
// is compared with the word the stack model handed out, in order.
module tb_lifo_drain_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef DRAIN_POPCNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset, drainEn, lifoPop, lifoEmpty, mValid, mReady, busy, drainDone;
    logic [DW-1:0] lifoData, mData;
    logic [CW-1:0] popCount;

    always #5 clock = ~clock;

    lifo_drain_ctrl #(.DATA_WIDTH(DW), .LIFO_DEPTH(DEPTH)) dut (
        .Clk(clock), .Rst(reset), .drain_en(drainEn), .lifo_pop(lifoPop),
        .lifo_data(lifoData), .lifo_empty(lifoEmpty), .m_valid(mValid), .m_ready(mReady),
        .m_data(mData), .busy(busy), .drain_done(drainDone), .pop_count(popCount)
    );

    logic [DW-1:0] stack[$];
    logic [DW-1:0] expQ[$];
    int assertCount = 0;
    int failCount   = 0;
    int cycleNum    = 0;
    int pending     = 0;
    bit popPrev = 1'b0, prevValid = 1'b0, prevReady = 1'b0, prevReset = 1'b1;
    logic [DW-1:0] prevData;
    logic sPop, sValid, sBusy, sDone;
    logic [DW-1:0] sData, firstFireData;
    logic [CW-1:0] sCount;
    int phasePops, phaseFires, phaseDone, firstPop, firstValid, firstFire, lastFire;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic startPhase();
        phasePops = 0; phaseFires = 0; phaseDone = 0;
        firstPop = -1; firstValid = -1; firstFire = -1; lastFire = -1;
        firstFireData = '0;
    endtask

    // One clock cycle: update the LIFO model for last cycle's pop, drive, sample, check.
    task automatic applyStimulus(input logic en, input logic rdy, input logic rst);
        logic          fire;
        logic [DW-1:0] word;
        if (popPrev && stack.size() != 0) begin
            word     = stack.pop_back();
            lifoData = word;
            expQ.push_back(word);
        end
        lifoEmpty = (stack.size() == 0);
        drainEn   = en;
        mReady    = rdy;
        reset     = rst;
        #1;
        fire   = mValid & mReady;
        sPop   = lifoPop; sValid = mValid; sData = mData;
        sBusy  = busy;    sDone  = drainDone; sCount = popCount;
        if (rst) begin
            checkOutput("popInReset", lifoPop, 0);
            expQ.delete();
            pending = 0;
            popPrev = 1'b0;
        end else begin
            checkOutput("popWhenEmpty", lifoPop & lifoEmpty, 0);
            checkOutput("popOverflow", lifoPop & ((pending - int'(fire)) >= 2), 0);
            if (!prevReset && prevValid && !prevReady) begin
                checkOutput("stallValid", mValid, 1);
                checkOutput("stallData", mData, prevData);
            end
            if (fire) begin
                checkOutput("fireHasWord", expQ.size() != 0, 1);
                if (expQ.size() != 0) checkOutput("fireData", mData, expQ.pop_front());
                if (firstFire < 0) begin
                    firstFire     = cycleNum;
                    firstFireData = mData;
                end
                lastFire = cycleNum;
                phaseFires++;
            end
            if (mValid === 1'b1 && firstValid < 0) firstValid = cycleNum;
            if (lifoPop) begin
                phasePops++;
                if (firstPop < 0) firstPop = cycleNum;
            end
            if (drainDone === 1'b1) phaseDone++;
            pending = pending + int'(lifoPop) - int'(fire);
            popPrev = lifoPop;
        end
        prevValid = mValid; prevReady = mReady; prevData = mData; prevReset = rst;
        cycleNum++;
        @(negedge clock);
    endtask

    task automatic runUntilDone(input int budget, input bit randRdy, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            applyStimulus(1'b1, randRdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            if (phaseDone != 0) seen = 1'b1;
        end
    endtask

    task automatic runUntilIdle(input int budget, input bit randRdy, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            applyStimulus(1'b0, randRdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            if (sBusy === 1'b0 && sValid === 1'b0) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        int abortPops;
        reset = 1'b1; drainEn = 1'b0; mReady = 1'b1; lifoData = '0;
        for (int i = 0; i < 16; i++) stack.push_back(DW'(i));
        lifoEmpty = 1'b0;
        @(negedge clock);

        // Reset held two cycles with drain_en high and a full LIFO.
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        startPhase();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("rstPop", sPop, 0);
        checkOutput("rstValid", sValid, 0);
        checkOutput("rstData", sData, 0);
        checkOutput("rstBusy", sBusy, 0);
        checkOutput("rstDone", sDone, 0);
        checkOutput("rstCount", sCount, 0);

        // Full-rate drain of 0x0F..0x00.
        runUntilDone(80, 1'b0, seen);
        checkOutput("fullDoneSeen", seen, 1);
        runUntilIdle(10, 1'b0, seen);
        checkOutput("fullIdle", seen, 1);
        checkOutput("fullFires", phaseFires, 16);
        checkOutput("fullPops", phasePops, 16);
        checkOutput("fullFirstData", firstFireData, 8'h0F);
        checkOutput("fullBackToBack", lastFire - firstFire, 15);
        checkOutput("fullLatency", firstValid - firstPop, 2);
        checkOutput("fullDoneOnce", phaseDone, 1);
        checkOutput("fullStackEmpty", stack.size(), 0);
        checkOutput("fullCount", sCount, CountEn ? 16 : 0);

        // Abort after three cycles of drain_en.
        for (int i = 0; i < 8; i++) stack.push_back(DW'(8'h20 + i));
        startPhase();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        runUntilIdle(20, 1'b0, seen);
        abortPops = phasePops;
        checkOutput("abortIdle", seen, 1);
        checkOutput("abortPopsLe3", (abortPops <= 3) && (abortPops > 0), 1);
        checkOutput("abortFires", phaseFires, abortPops);
        checkOutput("abortNoDone", phaseDone, 0);
        checkOutput("abortFirstData", firstFireData, 8'h27);
        checkOutput("abortLeft", stack.size(), 8 - abortPops);
        checkOutput("abortCount", sCount, CountEn ? abortPops : 0);

        // Next drain resumes with the words the abort left behind.
        startPhase();
        runUntilDone(60, 1'b0, seen);
        checkOutput("resumeDoneSeen", seen, 1);
        runUntilIdle(10, 1'b0, seen);
        checkOutput("resumeFires", phaseFires, 8 - abortPops);
        checkOutput("resumeFirstData", firstFireData, 8'h27 - abortPops);

        // Random backpressure over a full stack.
        for (int i = 0; i < 16; i++) stack.push_back(DW'(i));
        startPhase();
        runUntilDone(400, 1'b1, seen);
        checkOutput("bpDoneSeen", seen, 1);
        runUntilIdle(10, 1'b0, seen);
        checkOutput("bpFires", phaseFires, 16);
        checkOutput("bpFirstData", firstFireData, 8'h0F);
        checkOutput("bpDoneOnce", phaseDone, 1);
        checkOutput("bpCount", sCount, CountEn ? 16 : 0);

        // One-cycle drain_en pulse on an empty LIFO.
        startPhase();
        applyStimulus(1'b1, 1'b1, 1'b0);
        runUntilIdle(20, 1'b0, seen);
        checkOutput("emptyIdle", seen, 1);
        checkOutput("emptyPops", phasePops, 0);
        checkOutput("emptyNoValid", firstValid, -1);
        checkOutput("emptyDoneOnce", phaseDone, 1);
        checkOutput("emptyCount", sCount, 0);

        // Reset while the skid buffer is full and stalled.
        for (int i = 0; i < 8; i++) stack.push_back(DW'(8'h40 + i));
        startPhase();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("preRstPending", pending, 2);
        checkOutput("preRstValid", sValid, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        startPhase();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("midRstValid", sValid, 0);
        checkOutput("midRstBusy", sBusy, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("midRstNoWords", phaseFires, 0);
        checkOutput("midRstStack", stack.size(), 6);
        startPhase();
        runUntilDone(60, 1'b0, seen);
        checkOutput("postRstDoneSeen", seen, 1);
        checkOutput("postRstFirstData", firstFireData, 8'h45);
        checkOutput("postRstFires", phaseFires, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/lifo_drain_ctrl.md
Name: lifo_drain_ctrl

Overview:
Downstream consumer stage for the LIFO memory. Issues POP strobes to the LIFO and absorbs the LIFO's one-cycle read latency. Presents popped words on a valid/ready stream through a 2-entry skid buffer. A level-sensitive drain_en starts and stops draining, and drain_done pulses once the LIFO and the skid buffer are both exhausted.

Parameters:
DATA_WIDTH, 8, width of LIFO words and m_data
LIFO_DEPTH, 16, depth of the attached LIFO; sizes pop_count
CNT_W, $clog2(LIFO_DEPTH+1), width of pop_count

Ports:
Clk  input  1  clock; all logic on rising edge
Rst  input  1  synchronous, active-high reset
drain_en  input  1  level; 1 = drain the LIFO
lifo_pop  output  1  POP strobe to LIFO
lifo_data  input  DATA_WIDTH  LIFO dataOut
lifo_empty  input  1  LIFO EMPTY
m_valid  output  1  output word valid
m_ready  input  1  downstream ready
m_data  output  DATA_WIDTH  output word, top-of-stack order
busy  output  1  state != IDLE
drain_done  output  1  one-cycle pulse at drain completion
pop_count  output  CNT_W  pops issued this drain (only with DRAIN_POPCNT_EN)

Behaviour:
- Reset (Clk edge with Rst=1) clears the following: state=IDLE, lifo_pop=0, m_valid=0, m_data=0, busy=0, drain_done=0, pop_count=0, skid occupancy=0, in-flight flag=0, exhausted flag=0. Reset takes priority over every other event.
- Reset mid-drain discards buffered and in-flight words. The LIFO's own contents are not touched by this block.
- LIFO timing contract:
  - lifo_pop high in cycle t → popped word is on lifo_data during cycle t+1 and is captured at the end of t+1.
  - lifo_empty reflects all pops up to and including the previous cycle.
  - Back-to-back pops are legal.
- Fire = m_valid & m_ready. m_data and m_valid are registered. m_data holds stable while m_valid=1 and m_ready=0.
- Skid buffer: 2 entries, FIFO order. The head drives m_data. The captured word enters at the tail, or goes straight to the head when the buffer is empty.
- lifo_pop = (state==DRAIN) & drain_en & !lifo_empty & (occ + inflight - fire < 2). This never pops an empty LIFO and never overflows the skid buffer.
- Throughput: 1 word/cycle with m_ready held at 1.
- Latency: first m_valid appears 2 cycles after the first lifo_pop.
- FSM states and transitions:
  - IDLE: drain_en=1 → DRAIN. Clear exhausted flag. Clear pop_count.
  - DRAIN:
    - lifo_empty=1 → FLUSH with exhausted=1.
    - drain_en=0 (abort) → FLUSH with exhausted=0. No pop is issued in the abort cycle.
  - FLUSH: no pops. When inflight=0 and occ=0: → DONE if exhausted, else → IDLE.
  - DONE: drain_done=1 for exactly this cycle, then → IDLE, regardless of drain_en.
- drain_en still 1 on return to IDLE → re-enter DRAIN next cycle. Entering DRAIN with lifo_empty=1 gives DRAIN→FLUSH→DONE with zero words output.
- Words output always equals pops issued. No word is dropped or duplicated under any m_ready pattern.
- drain_en is don't-care in FLUSH and DONE.

Optional Feature:
DRAIN_POPCNT_EN
- Defined: pop_count increments on each lifo_pop and clears on IDLE→DRAIN. It holds its value through FLUSH, DONE and IDLE. It saturates at LIFO_DEPTH.
- Undefined: the pop_count port is still present, tied to 0, with no counter logic.

Test Plan:
- Reset: LIFO holds 16 words, Rst=1 for 2 cycles while drain_en=1 → all outputs 0, lifo_pop never asserted during reset.
- Full-rate drain: push 0x00..0x0F, drain_en=1, m_ready=1 → m_data 0x0F,0x0E,…,0x00 on 16 consecutive cycles. First m_valid 2 cycles after first lifo_pop. drain_done pulses once. pop_count=16 (DRAIN_POPCNT_EN).
- Backpressure: same 16 words, m_ready toggles 1,0,0,1… randomly → same 16-word descending sequence, m_data stable while stalled. lifo_pop never asserted when occ+inflight-fire=2. lifo_pop never asserted while lifo_empty=1.
- Abort: push 8 words, drain_en=1 for 3 cycles then 0, m_ready=1 → exactly as many words out as pops issued (≤3, top-first). No drain_done. busy falls. The remaining words stay in the LIFO and are output first on the next drain.
- Empty start: empty LIFO, drain_en pulse 1 cycle → no lifo_pop, no m_valid, drain_done pulses once, back to IDLE.
- Reset mid-drain: Rst for 1 cycle while m_valid=1, m_ready=0, occ=2 → m_valid=0 the next cycle, state IDLE, buffered words discarded.
